myproject_mul_share_arb: RTL and testbench

Round-robin arbiter and pipeline controller that time-shares one signed 33×6 multiplier datapath among NUM_REQ requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester per cycle, registers the operands, and multiplies them. It returns the truncated product, tagged with the requester index, on a single valid/ready response port. It sits between the MHA score/scale loops and the shared multiplier resource, so concurrent loop bodies no longer need dedicated DSP instances.

---
 rtl/myproject_mul_share_arb.sv | 148 ++++++++++++++
 tb/tb_myproject_mul_share_arb.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/myproject_mul_share_arb.sv
// ----------------------------------------------------------------------------
// myproject_mul_share_arb
//
// Round-robin arbiter in front of one shared signed DIN0_WIDTH x DIN1_WIDTH
// multiplier. Each cycle one requester is granted, and its operands go into
// the operand stage (p1). The next stage (p2) holds the product truncated to
// DOUT_WIDTH bits, tagged with the index of the requester that issued it. The
// product is then presented on a single valid/ready response port. The two
// stages stall together under response backpressure, so nothing is dropped.
//
// Ports
//   ap_clk     in   clock, rising edge
//   ap_rst     in   synchronous active-high reset
//   req_valid  in   [NUM_REQ]             per-requester operand valid
//   req_ready  out  [NUM_REQ]             per-requester accept (one-hot or 0)
//   req_din0   in   [NUM_REQ*DIN0_WIDTH]  operand A, requester i at i*DIN0_WIDTH
//   req_din1   in   [NUM_REQ*DIN1_WIDTH]  operand B, same packing
//   rsp_valid  out  product valid
//   rsp_ready  in   consumer accept
//   rsp_dout   out  [DOUT_WIDTH]          low bits of the signed product
//   rsp_id     out  [ID_WIDTH]            index of the issuing requester
// ----------------------------------------------------------------------------
module myproject_mul_share_arb #(
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = 2,
    parameter int DIN0_WIDTH = 33,
    parameter int DIN1_WIDTH = 6,
    parameter int DOUT_WIDTH = 36
) (
    input  logic                           ap_clk,
    input  logic                           ap_rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*DIN0_WIDTH-1:0]  req_din0,
    input  logic [NUM_REQ*DIN1_WIDTH-1:0]  req_din1,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic signed [DOUT_WIDTH-1:0]   rsp_dout,
    output logic [ID_WIDTH-1:0]            rsp_id
);

    localparam int PROD_W = DIN0_WIDTH + DIN1_WIDTH;

    // Keep only the low DOUT_WIDTH bits; the upper bits wrap, no saturation.
    function automatic logic signed [DOUT_WIDTH-1:0] trunc_prod(
        input logic signed [PROD_W-1:0] p
    );
        return p[DOUT_WIDTH-1:0];
    endfunction

    logic [ID_WIDTH-1:0]            r_rr_ptr;
    logic signed [DIN0_WIDTH-1:0]   r_din0_p1;
    logic signed [DIN1_WIDTH-1:0]   r_din1_p1;
    logic [ID_WIDTH-1:0]            r_id_p1;
    logic                           r_vld_p1;
    logic signed [DOUT_WIDTH-1:0]   r_dout_p2;
    logic [ID_WIDTH-1:0]            r_id_p2;
    logic                           r_vld_p2;

    logic                           w_s2_en;
    logic                           w_s1_en;
    logic                           w_found;
    logic                           w_accept;
    logic [ID_WIDTH-1:0]            w_grant;
    logic [ID_WIDTH-1:0]            w_next_ptr;
    logic signed [DIN0_WIDTH-1:0]   w_gdin0;
    logic signed [DIN1_WIDTH-1:0]   w_gdin1;
    logic signed [PROD_W-1:0]       w_prod_p1;
    int                             w_scan_idx;

    assign w_s2_en  = !r_vld_p2 || rsp_ready;
    assign w_s1_en  = !r_vld_p1 || w_s2_en;
    assign w_accept = w_s1_en && w_found && !ap_rst;

    // Scan from the lowest priority offset up to rr_ptr so the last hit
    // (closest to rr_ptr in search order) wins.
    always_comb begin
        w_found    = 1'b0;
        w_grant    = '0;
        w_scan_idx = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_scan_idx = int'(r_rr_ptr) + k;
            if (w_scan_idx >= NUM_REQ) begin
                w_scan_idx = w_scan_idx - NUM_REQ;
            end
            for (int j = 0; j < NUM_REQ; j++) begin
                if (j == w_scan_idx && req_valid[j]) begin
                    w_found = 1'b1;
                    w_grant = ID_WIDTH'(j);
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        w_gdin0   = '0;
        w_gdin1   = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (w_grant == ID_WIDTH'(j)) begin
                req_ready[j] = w_accept;
                w_gdin0      = req_din0[j*DIN0_WIDTH +: DIN0_WIDTH];
                w_gdin1      = req_din1[j*DIN1_WIDTH +: DIN1_WIDTH];
            end
        end
    end

    assign w_next_ptr = (w_grant == ID_WIDTH'(NUM_REQ - 1)) ? '0
                                                             : w_grant + ID_WIDTH'(1);

    // p1 -> p2: full-width signed multiply of the registered operands.
    assign w_prod_p1 = PROD_W'(r_din0_p1) * PROD_W'(r_din1_p1);

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_rr_ptr  <= '0;
            r_din0_p1 <= '0;
            r_din1_p1 <= '0;
            r_id_p1   <= '0;
            r_vld_p1  <= 1'b0;
            r_dout_p2 <= '0;
            r_id_p2   <= '0;
            r_vld_p2  <= 1'b0;
        end else begin
            if (w_s2_en) begin
                r_dout_p2 <= trunc_prod(w_prod_p1);
                r_id_p2   <= r_id_p1;
                r_vld_p2  <= r_vld_p1;
            end
            if (w_s1_en) begin
                if (w_accept) begin
                    r_din0_p1 <= w_gdin0;
                    r_din1_p1 <= w_gdin1;
                    r_id_p1   <= w_grant;
                    r_vld_p1  <= 1'b1;
                    r_rr_ptr  <= w_next_ptr;
                end else begin
                    r_vld_p1  <= 1'b0;
                end
            end
        end
    end

    assign rsp_valid = r_vld_p2;
    assign rsp_dout  = r_dout_p2;
    assign rsp_id    = r_id_p2;

endmodule

// File: tb/tb_myproject_mul_share_arb.sv
module tb_myproject_mul_share_arb;

    localparam int NR = 4;
    localparam int IW = 2;
    localparam int AW = 33;
    localparam int BW = 6;
    localparam int DW = 36;

    logic                ap_clk = 1'b0;
    logic                ap_rst;
    logic [NR-1:0]       req_valid;
    logic [NR-1:0]       req_ready;
    logic [NR*AW-1:0]    req_din0;
    logic [NR*BW-1:0]    req_din1;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [DW-1:0]       rsp_dout;
    logic [IW-1:0]       rsp_id;

    myproject_mul_share_arb #(
        .NUM_REQ(NR), .ID_WIDTH(IW), .DIN0_WIDTH(AW), .DIN1_WIDTH(BW), .DOUT_WIDTH(DW)
    ) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_din0(req_din0), .req_din1(req_din1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_dout(rsp_dout), .rsp_id(rsp_id)
    );

    always #5 ap_clk = ~ap_clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Behavioural model: ordered list of in-flight products, each tagged
    // with whether it has reached the output register yet.
    typedef struct {
        int            id;
        logic [DW-1:0] dout;
        int            stage;
    } item_t;

    item_t         mq[$];
    int            m_ptr  = 0;
    bit            chk_en = 1'b0;
    int            cyc    = 0;
    int            acc_log[$];
    int            rsp_id_log[$];
    logic [DW-1:0] rsp_dout_log[$];
    int            rsp_cyc_log[$];

    function automatic logic [DW-1:0] ref_prod(input int i);
        logic [AW-1:0] a;
        logic [BW-1:0] b;
        longint        p;
        a = AW'(req_din0 >> (i * AW));
        b = BW'(req_din1 >> (i * BW));
        p = longint'($signed(a)) * longint'($signed(b));
        return p[DW-1:0];
    endfunction

    always @(negedge ap_clk) begin : chk
        bit            mv;
        bit            s2en;
        bit            s1busy;
        bit            s1en;
        int            g;
        int            idx;
        logic [NR-1:0] exp_rdy;
        item_t         it;
        if (chk_en) begin
            cyc++;
            mv     = (mq.size() > 0) && (mq[0].stage == 2);
            s2en   = !mv || rsp_ready;
            s1busy = (mq.size() > 0) && (mq[mq.size()-1].stage == 1);
            s1en   = !s1busy || s2en;
            g = -1;
            for (int k = 0; k < NR; k++) begin
                idx = (m_ptr + k) % NR;
                if (g < 0 && ((req_valid >> idx) & NR'(1)) != 0) g = idx;
            end
            exp_rdy = '0;
            if (!ap_rst && s1en && g >= 0) exp_rdy = NR'(1) << g;
            check("req_ready", 64'(req_ready), 64'(exp_rdy));
            check("rsp_valid", 64'(rsp_valid), 64'(mv));
            if (mv) begin
                check("rsp_dout", 64'(rsp_dout), 64'(mq[0].dout));
                check("rsp_id", 64'(rsp_id), 64'(mq[0].id));
            end
            for (int i = 0; i < NR; i++)
                if (((req_valid & req_ready) >> i) & NR'(1)) acc_log.push_back(i);
            if (rsp_valid && rsp_ready) begin
                rsp_id_log.push_back(int'(rsp_id));
                rsp_dout_log.push_back(rsp_dout);
                rsp_cyc_log.push_back(cyc);
            end
            if (ap_rst) begin
                mq.delete();
                m_ptr = 0;
            end else begin
                if (mv && rsp_ready) void'(mq.pop_front());
                if (s2en) begin
                    for (int i = 0; i < mq.size(); i++)
                        if (mq[i].stage == 1) mq[i].stage = 2;
                end
                if (exp_rdy != '0) begin
                    it.id    = g;
                    it.dout  = ref_prod(g);
                    it.stage = 1;
                    mq.push_back(it);
                    m_ptr = (g + 1) % NR;
                end
            end
        end
    end

    task automatic set_ops(input int i, input logic [AW-1:0] a, input logic [BW-1:0] b);
        req_din0[i*AW +: AW] = a;
        req_din1[i*BW +: BW] = b;
    endtask

    task automatic idle();
        repeat (3) @(posedge ap_clk);
        #1;
    endtask

    task automatic clear_logs();
        acc_log.delete();
        rsp_id_log.delete();
        rsp_dout_log.delete();
        rsp_cyc_log.delete();
    endtask

    // which: 0 = grant log, 1 = response id log
    task automatic check_seq(input string nm, input int which, input int n, input int e[8]);
        int sz;
        int v;
        sz = (which == 0) ? acc_log.size() : rsp_id_log.size();
        check({nm, "_count"}, 64'(sz), 64'(n));
        for (int i = 0; i < n; i++) begin
            v = -1;
            if (i < sz) v = (which == 0) ? acc_log[i] : rsp_id_log[i];
            check($sformatf("%s_%0d", nm, i), 64'(v), 64'(e[i]));
        end
    endtask

    task automatic single_op(input int idx, input logic [AW-1:0] a, input logic [BW-1:0] b,
                             input logic [DW-1:0] exp_d, input string nm);
        bit got;
        set_ops(idx, a, b);
        rsp_ready = 1'b1;
        req_valid = NR'(1) << idx;
        got = 1'b0;
        for (int n = 0; n < 10 && !got; n++) begin
            @(negedge ap_clk);
            if (req_ready != '0) got = 1'b1;
        end
        check({nm, "_granted"}, 64'(got), 64'd1);
        @(posedge ap_clk);
        #1 req_valid = '0;
        @(negedge ap_clk);
        check({nm, "_early_valid"}, 64'(rsp_valid), 64'd0);
        @(negedge ap_clk);
        check({nm, "_valid"}, 64'(rsp_valid), 64'd1);
        check({nm, "_dout"}, 64'(rsp_dout), 64'(exp_d));
        check({nm, "_id"}, 64'(rsp_id), 64'(idx));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ap_rst    = 1'b1;
        req_valid = '1;
        req_din0  = '0;
        req_din1  = '0;
        rsp_ready = 1'b1;
        @(posedge ap_clk);
        #1 chk_en = 1'b1;
        @(negedge ap_clk);
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_rsp_dout", 64'(rsp_dout), 64'd0);
        check("reset_rsp_id", 64'(rsp_id), 64'd0);
        check("reset_req_ready", 64'(req_ready), 64'd0);
        @(posedge ap_clk);
        #1 ap_rst = 1'b0;
        req_valid = '0;

        single_op(2, '1, 6'd5, 36'hFFFFFFFFB, "single");
        idle();
        single_op(0, 33'h0FFFFFFFF, 6'b100000, 36'h000000020, "trunc1");
        idle();
        single_op(0, 33'h100000000, 6'b100000, 36'h000000000, "trunc2");
        idle();
        single_op(3, 33'd7, 6'h3D, 36'hFFFFFFFEB, "neg");
        idle();

        // Round-robin with all requesters valid, rr_ptr at 0.
        for (int i = 0; i < NR; i++) set_ops(i, AW'(100 * (i + 1)), BW'(-(i + 1)));
        clear_logs();
        req_valid = '1;
        repeat (8) @(posedge ap_clk);
        #1 req_valid = '0;
        idle();
        check_seq("rr_grant", 0, 8, '{0, 1, 2, 3, 0, 1, 2, 3});
        check_seq("rr_rsp", 1, 8, '{0, 1, 2, 3, 0, 1, 2, 3});
        check("rr_dout0", 64'(rsp_dout_log.size() > 0 ? rsp_dout_log[0] : '0), 64'(36'hFFFFFFF9C));
        check("rr_dout1", 64'(rsp_dout_log.size() > 1 ? rsp_dout_log[1] : '0), 64'(36'hFFFFFFE70));
        check("rr_back_to_back", 64'(rsp_cyc_log.size() == 8 ? rsp_cyc_log[7] - rsp_cyc_log[0] : -1), 64'd7);

        // Backpressure: two products buffered, then everything stalls.
        clear_logs();
        rsp_ready = 1'b0;
        req_valid = '1;
        repeat (5) @(posedge ap_clk);
        #1;
        check("bp_accepts", 64'(acc_log.size()), 64'd2);
        check("bp_ready_blocked", 64'(req_ready), 64'd0);
        check("bp_hold_valid", 64'(rsp_valid), 64'd1);
        check("bp_hold_dout", 64'(rsp_dout), 64'(36'hFFFFFFF9C));
        check("bp_hold_id", 64'(rsp_id), 64'd0);
        rsp_ready = 1'b1;
        repeat (4) @(posedge ap_clk);
        #1 req_valid = '0;
        idle();
        check_seq("bp_grant", 0, 6, '{0, 1, 2, 3, 0, 1, 0, 0});
        check_seq("bp_rsp", 1, 6, '{0, 1, 2, 3, 0, 1, 0, 0});

        // Skip/wrap: move rr_ptr to 0, then only 1 and 3 request.
        single_op(3, 33'd1, 6'd1, 36'd1, "ptr3");
        idle();
        clear_logs();
        req_valid = 4'b1010;
        repeat (4) @(posedge ap_clk);
        #1 req_valid = 4'b1011;
        @(posedge ap_clk);
        #1 req_valid = '0;
        idle();
        check_seq("wrap_grant", 0, 5, '{1, 3, 1, 3, 0, 0, 0, 0});
        check_seq("wrap_rsp", 1, 5, '{1, 3, 1, 3, 0, 0, 0, 0});

        // Reset while both stages are full and stalled.
        rsp_ready = 1'b0;
        req_valid = '1;
        repeat (3) @(posedge ap_clk);
        #1;
        check("rst_pre_full", 64'(rsp_valid), 64'd1);
        clear_logs();
        ap_rst = 1'b1;
        @(negedge ap_clk);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        @(posedge ap_clk);
        #1;
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_req_ready_after", 64'(req_ready), 64'd0);
        ap_rst    = 1'b0;
        rsp_ready = 1'b1;
        req_valid = 4'b1100;
        repeat (2) @(posedge ap_clk);
        #1 req_valid = '0;
        idle();
        check_seq("rst_grant", 0, 2, '{2, 3, 0, 0, 0, 0, 0, 0});
        check_seq("rst_rsp", 1, 2, '{2, 3, 0, 0, 0, 0, 0, 0});

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
